dpwm_multicanal_dt: RTL and testbench

Parametrised multi-channel digital PWM core, successor to the single-channel duty/frequency modulator in the DPWM design. It generates CANALES phase-aligned PWM channels from one shared period counter. Each channel supports single-ended or complementary output with programmable dead time. Period, duty, dead time and mode go through shadow registers that load only at a period boundary. It sits between the user-control logic (button counters, display FSM) and the power-stage output distribution.

---
 rtl/dpwm_multicanal_dt.sv | 115 +++++++++++
 tb/tb_dpwm_multicanal_dt.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpwm_multicanal_dt.sv
// Multi-channel digital PWM with one shared period counter, per-channel complementary outputs
// with programmable dead time, and shadowed settings that load only at a period wrap.
module dpwm_multicanal_dt #(
  parameter int unsigned ANCHO    = 8,
  parameter int unsigned CANALES  = 2,
  parameter int unsigned ANCHO_DT = 4
) (
  input  logic                       CLK_100MHz,
  input  logic                       reset,
  input  logic                       enable_tick,
  input  logic [ANCHO-1:0]           periodo,
  input  logic [CANALES*ANCHO-1:0]   ciclo,
  input  logic [ANCHO_DT-1:0]        tiempo_muerto,
  input  logic                       modo,
  input  logic [CANALES-1:0]         habilitar_canal,
  input  logic                       actualizar,
  output logic [ANCHO-1:0]           cuenta,
  output logic [CANALES-1:0]         pwm_h,
  output logic [CANALES-1:0]         pwm_l,
  output logic                       inicio_periodo,
  output logic                       actualizado
);

  localparam logic [ANCHO-1:0]    UnoCuenta = {{(ANCHO-1){1'b0}}, 1'b1};
  localparam logic [ANCHO_DT-1:0] UnoDt     = {{(ANCHO_DT-1){1'b0}}, 1'b1};

  logic [ANCHO-1:0]    cuenta_q, cuenta_d;
  logic [ANCHO-1:0]    periodo_act_q;
  logic [ANCHO-1:0]    ciclo_act_q [CANALES];
  logic [ANCHO_DT-1:0] dt_act_q;
  logic                modo_act_q;
  logic                pendiente_q, pendiente_d;
  logic [CANALES-1:0]  ref_q, ref_d;
  logic [ANCHO_DT-1:0] dt_q [CANALES];
  logic [ANCHO_DT-1:0] dt_d [CANALES];
  logic [CANALES-1:0]  en_q;
  logic                inicio_q, actualizado_q;
  logic                wrap, carga;

  always_comb begin
    wrap        = enable_tick && (cuenta_q >= periodo_act_q);
    carga       = wrap && (pendiente_q || actualizar);
    cuenta_d    = cuenta_q;
    if (enable_tick) begin
      cuenta_d = wrap ? '0 : cuenta_q + UnoCuenta;
    end
    pendiente_d = carga ? 1'b0 : (pendiente_q || actualizar);
  end

  // Dead-time counter restarts on any event that could change which gate should conduct.
  always_comb begin
    for (int i = 0; i < CANALES; i++) begin
      ref_d[i] = cuenta_q < ciclo_act_q[i];
      dt_d[i]  = dt_q[i];
      if (carga) begin
        dt_d[i] = tiempo_muerto;
      end else if ((ref_d[i] != ref_q[i]) || (habilitar_canal[i] && !en_q[i])) begin
        dt_d[i] = dt_act_q;
      end else if (dt_q[i] != '0) begin
        dt_d[i] = dt_q[i] - UnoDt;
      end
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (reset) begin
      cuenta_q      <= '0;
      periodo_act_q <= '1;
      dt_act_q      <= '0;
      modo_act_q    <= 1'b0;
      pendiente_q   <= 1'b0;
      ref_q         <= '0;
      en_q          <= '0;
      inicio_q      <= 1'b0;
      actualizado_q <= 1'b0;
      for (int i = 0; i < CANALES; i++) begin
        ciclo_act_q[i] <= '0;
        dt_q[i]        <= '0;
      end
    end else begin
      cuenta_q      <= cuenta_d;
      pendiente_q   <= pendiente_d;
      ref_q         <= ref_d;
      en_q          <= habilitar_canal;
      inicio_q      <= wrap;
      actualizado_q <= carga;
      if (carga) begin
        periodo_act_q <= periodo;
        dt_act_q      <= tiempo_muerto;
        modo_act_q    <= modo;
      end
      for (int i = 0; i < CANALES; i++) begin
        dt_q[i] <= dt_d[i];
        if (carga) begin
          ciclo_act_q[i] <= ciclo[i*ANCHO +: ANCHO];
        end
      end
    end
  end

  // The live enable only gates the registered decode, so a channel shuts off in the same cycle.
  always_comb begin
    for (int i = 0; i < CANALES; i++) begin
      pwm_h[i] = ref_q[i] && habilitar_canal[i] && en_q[i] &&
                 (!modo_act_q || (dt_q[i] == '0));
      pwm_l[i] = !ref_q[i] && habilitar_canal[i] && en_q[i] && modo_act_q &&
                 (dt_q[i] == '0);
    end
  end

  assign cuenta         = cuenta_q;
  assign inicio_periodo = inicio_q;
  assign actualizado    = actualizado_q;

endmodule

// File: tb/tb_dpwm_multicanal_dt.sv
// Directed bench for dpwm_multicanal_dt: a table of shadow configurations with per-period
// gate counts, plus sequences for reset, shadow isolation, sparse ticks, enable and reset.
module tb_dpwm_multicanal_dt;

  logic        CLK_100MHz = 1'b0;
  logic        reset;
  logic        enable_tick;
  logic [7:0]  periodo;
  logic [15:0] ciclo;
  logic [3:0]  tiempo_muerto;
  logic        modo;
  logic [1:0]  habilitar_canal;
  logic        actualizar;
  logic [7:0]  cuenta;
  logic [1:0]  pwm_h, pwm_l;
  logic        inicio_periodo, actualizado;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  logic sparse = 1'b0;
  int cyc = 0;

  always #5 CLK_100MHz = ~CLK_100MHz;

  dpwm_multicanal_dt #(.ANCHO(8), .CANALES(2), .ANCHO_DT(4)) dut (
    .CLK_100MHz      (CLK_100MHz),
    .reset           (reset),
    .enable_tick     (enable_tick),
    .periodo         (periodo),
    .ciclo           (ciclo),
    .tiempo_muerto   (tiempo_muerto),
    .modo            (modo),
    .habilitar_canal (habilitar_canal),
    .actualizar      (actualizar),
    .cuenta          (cuenta),
    .pwm_h           (pwm_h),
    .pwm_l           (pwm_l),
    .inicio_periodo  (inicio_periodo),
    .actualizado     (actualizado)
  );

  always @(negedge CLK_100MHz) begin
    cyc++;
    enable_tick = sparse ? ((cyc % 4) == 0) : 1'b1;
    if ((pwm_h & pwm_l) != 2'b00) overlap++;
  end

  typedef struct {
    logic [7:0] periodo;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [3:0] dt;
    logic       modo;
    int         h0;
    int         l0;
    int         h1;
    int         l1;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_actualizar();
    @(posedge CLK_100MHz);
    #1 actualizar = 1'b1;
    @(posedge CLK_100MHz);
    #1 actualizar = 1'b0;
  endtask

  task automatic wait_act(output int found);
    found = 0;
    for (int k = 0; k < 600 && found == 0; k++) begin
      @(negedge CLK_100MHz);
      if (actualizado) found = 1;
    end
  endtask

  task automatic wait_inicio(output int n);
    n = 0;
    do begin
      @(negedge CLK_100MHz);
      n++;
    end while (!inicio_periodo && n < 60);
  endtask

  task automatic wait_cuenta(input int val, output int found);
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      @(negedge CLK_100MHz);
      if (cuenta == val) found = 1;
    end
  endtask

  initial begin
    int found, n, h0, l0, h1, l1, ini, act, first, gap;

    vecs[0] = '{8'd9,  8'd5, 8'd0,  4'd2, 1'b1, 3, 3, 0, 10};
    vecs[1] = '{8'd9,  8'd3, 8'd7,  4'd4, 1'b1, 0, 3, 3, 0};
    vecs[2] = '{8'd15, 8'd8, 8'd16, 4'd1, 1'b1, 7, 7, 16, 0};
    vecs[3] = '{8'd4,  8'd2, 8'd1,  4'd0, 1'b1, 2, 3, 1, 4};
    vecs[4] = '{8'd7,  8'd0, 8'd7,  4'd3, 1'b0, 0, 0, 7, 0};
    vecs[5] = '{8'd9,  8'd3, 8'd10, 4'd0, 1'b0, 3, 0, 10, 0};

    reset = 1'b1;
    enable_tick = 1'b1;
    periodo = 8'd9;
    ciclo = {8'd10, 8'd3};
    tiempo_muerto = 4'd0;
    modo = 1'b0;
    habilitar_canal = 2'b11;
    actualizar = 1'b0;

    // Reset state, then free run on the reset period of 256 clocks.
    repeat (3) @(negedge CLK_100MHz);
    check("rst_cuenta", cuenta, 0);
    check("rst_pwm_h", pwm_h, 0);
    check("rst_pwm_l", pwm_l, 0);
    check("rst_inicio", inicio_periodo, 0);
    check("rst_actualizado", actualizado, 0);
    reset = 1'b0;
    ini = 0; act = 0; h0 = 0; first = 0; gap = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge CLK_100MHz);
      if (k == 100) check("free_cuenta100", cuenta, 100);
      if (inicio_periodo) begin
        ini++;
        if (first != 0) gap = k - first;
        else first = k;
        check("free_wrap_cuenta0", cuenta, 0);
      end
      if (actualizado) act++;
      if ((pwm_h | pwm_l) != 2'b00) h0++;
    end
    check("free_inicio_count", ini, 2);
    check("free_inicio_first", first, 256);
    check("free_period", gap, 256);
    check("free_no_update", act, 0);
    check("free_outputs_low", h0, 0);

    // Table of shadow configurations.
    for (int i = 0; i < 6; i++) begin
      periodo = vecs[i].periodo;
      ciclo = {vecs[i].c1, vecs[i].c0};
      tiempo_muerto = vecs[i].dt;
      modo = vecs[i].modo;
      pulse_actualizar();
      wait_act(found);
      check($sformatf("v%0d_load", i), found, 1);
      check($sformatf("v%0d_cuenta_at_load", i), cuenta, 0);
      act = 0;
      for (int k = 0; k <= int'(vecs[i].periodo); k++) begin
        @(negedge CLK_100MHz);
        if (actualizado) act++;
      end
      h0 = 0; l0 = 0; h1 = 0; l1 = 0; ini = 0;
      for (int k = 0; k <= int'(vecs[i].periodo); k++) begin
        @(negedge CLK_100MHz);
        h0 += int'(pwm_h[0]);
        l0 += int'(pwm_l[0]);
        h1 += int'(pwm_h[1]);
        l1 += int'(pwm_l[1]);
        ini += int'(inicio_periodo);
        if (actualizado) act++;
      end
      check($sformatf("v%0d_h0", i), h0, vecs[i].h0);
      check($sformatf("v%0d_l0", i), l0, vecs[i].l0);
      check($sformatf("v%0d_h1", i), h1, vecs[i].h1);
      check($sformatf("v%0d_l1", i), l1, vecs[i].l1);
      check($sformatf("v%0d_inicio", i), ini, 1);
      check($sformatf("v%0d_single_update", i), act, 0);
    end

    // New duty without a request must not take effect; a request at cuenta=4 lands at wrap.
    ciclo = {8'd10, 8'd7};
    repeat (20) @(negedge CLK_100MHz);
    h0 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK_100MHz);
      h0 += int'(pwm_h[0]);
    end
    check("shadow_hold_h0", h0, 3);
    wait_cuenta(4, found);
    check("shadow_find_c4", found, 1);
    actualizar = 1'b1;
    @(posedge CLK_100MHz);
    #1 actualizar = 1'b0;
    wait_act(found);
    check("shadow_load", found, 1);
    check("shadow_load_cuenta", cuenta, 0);
    h0 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge CLK_100MHz);
      h0 += int'(pwm_h[0]);
    end
    check("shadow_new_h0", h0, 7);
    act = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK_100MHz);
      act += int'(actualizado);
    end
    check("shadow_single_pulse", act, 0);

    // Sparse ticks: period of 4*(3+1) clocks while dead time still counts in clocks.
    periodo = 8'd3;
    ciclo = {8'd4, 8'd2};
    tiempo_muerto = 4'd2;
    modo = 1'b1;
    pulse_actualizar();
    wait_act(found);
    check("sparse_load", found, 1);
    sparse = 1'b1;
    wait_inicio(n);
    wait_inicio(n);
    h0 = 0; l0 = 0; h1 = 0; n = 0;
    do begin
      @(negedge CLK_100MHz);
      n++;
      h0 += int'(pwm_h[0]);
      l0 += int'(pwm_l[0]);
      h1 += int'(pwm_h[1]);
    end while (!inicio_periodo && n < 60);
    check("sparse_period", n, 16);
    check("sparse_h0", h0, 6);
    check("sparse_l0", l0, 6);
    check("sparse_h1", h1, 16);

    // Channel disable takes effect within the same cycle.
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge CLK_100MHz);
      if (pwm_h[0]) found = 1;
    end
    check("drop_find_high", found, 1);
    habilitar_canal[0] = 1'b0;
    #1;
    check("drop_h0", pwm_h[0], 0);
    check("drop_l0", pwm_l[0], 0);
    check("drop_h1_unaffected", pwm_h[1], 1);

    // Re-enable while ref is steadily high: two dead-time clocks, then pwm_h resumes.
    wait_inicio(n);
    repeat (4) @(negedge CLK_100MHz);
    check("reen_cuenta", cuenta, 1);
    habilitar_canal[0] = 1'b1;
    check("reen_h0_now", pwm_h[0], 0);
    @(negedge CLK_100MHz);
    check("reen_h0_dt1", pwm_h[0], 0);
    check("reen_l0_dt1", pwm_l[0], 0);
    @(negedge CLK_100MHz);
    check("reen_h0_dt2", pwm_h[0], 0);
    check("reen_l0_dt2", pwm_l[0], 0);
    @(negedge CLK_100MHz);
    check("reen_h0_resume", pwm_h[0], 1);

    // Reset mid-period.
    wait_cuenta(2, found);
    check("mid_find_c2", found, 1);
    reset = 1'b1;
    @(negedge CLK_100MHz);
    check("mid_rst_cuenta", cuenta, 0);
    check("mid_rst_pwm_h", pwm_h, 0);
    check("mid_rst_pwm_l", pwm_l, 0);
    check("mid_rst_inicio", inicio_periodo, 0);
    @(negedge CLK_100MHz);
    reset = 1'b0;
    ini = 0; h0 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK_100MHz);
      ini += int'(inicio_periodo);
      if ((pwm_h | pwm_l) != 2'b00) h0++;
    end
    check("post_rst_no_inicio", ini, 0);
    check("post_rst_outputs_low", h0, 0);

    check("never_both_high", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
